tile_recorder: RTL and testbench

Chart recorder for the piano-tile game: samples the three player buttons, folds every press inside one beat into a 3-bit lane pattern and writes one pattern per beat into an on-chip chart memory. It is the write side of the game's 3-bit-per-beat chart stream, with the same lane encoding and beat pacing the playback path consumes. A registered read port exposes the recorded chart to the playback path or to a dump/debug path.

---
 rtl/tile_recorder.sv | 121 ++++++++++++
 tb/tb_tile_recorder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_recorder.sv
`default_nettype none
// tile_recorder: folds every button press inside one beat into a 3-bit lane
// pattern, records one pattern per beat into chart memory, and offers a registered read port.
module tile_recorder #(
    parameter int DEPTH    = 100,
    parameter int ADDR_W   = 7,
    parameter int BEAT_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn1,
    input  logic              btn2,
    input  logic              btn3,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        rd_data,
    output logic              recording,
    output logic              done,
    output logic [ADDR_W-1:0] count,
    output logic [2:0]        LED
);
    localparam int                BEAT_W     = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEAT_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [2:0]          btn_meta;
    logic [2:0]          btn_sync;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [2:0]          acc;
    logic                tick;
    logic                take_start;
    logic [2:0]          mem [DEPTH];

    always_comb begin
        state_nx   = state;
        tick       = 1'b0;
        take_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx   = REC;
                    take_start = 1'b1;
                end
            end
            REC: begin
                tick = (beat_cnt == BEAT_LAST);
                // A stop on a tick still lets that beat's write land first.
                if ((tick && (count == LAST_ENTRY)) || stop) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 3'b000;
            btn_sync <= 3'b000;
            beat_cnt <= '0;
            acc      <= 3'b000;
            count    <= '0;
        end else begin
            btn_meta <= {btn3, btn2, btn1};
            btn_sync <= btn_meta;
            if (take_start) begin
                count    <= '0;
                beat_cnt <= '0;
                acc      <= 3'b000;
            end else if (state == REC) begin
                if (tick) begin
                    count    <= count + ADDR_W'(1);
                    beat_cnt <= '0;
                    acc      <= 3'b000;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                    acc      <= acc | btn_sync;
                end
            end
        end
    end

    // Chart storage survives reset and new takes; only ticks overwrite it.
    always_ff @(posedge clk) begin
        if (tick) begin
            mem[count] <= acc | btn_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= 3'b000;
        end else begin
            rd_data <= ({1'b0, rd_addr} < DEPTH_X) ? mem[rd_addr] : 3'b000;
        end
    end

    assign recording = (state == REC);
    assign done      = (state == DONE);
    assign LED       = recording ? acc : 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_tile_recorder.sv
`default_nettype none
// Directed bench for tile_recorder with a small chart (DEPTH=4, BEAT_DIV=8).
module tb_tile_recorder;
    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 3;
    localparam int BEAT_DIV = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              btn1, btn2, btn3;
    logic              start, stop;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_data;
    logic              recording;
    logic              done;
    logic [ADDR_W-1:0] count;
    logic [2:0]        led;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          t        = 0;
    logic [2:0]  exp_mem [0:7];
    logic [2:0]  exp_q [$];

    tile_recorder #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .BEAT_DIV(BEAT_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn1     (btn1),
        .btn2     (btn2),
        .btn3     (btn3),
        .start    (start),
        .stop     (stop),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .recording(recording),
        .done     (done),
        .count    (count),
        .LED      (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        t++;
    endtask

    task automatic goto(input int n);
        while (t < n) step();
    endtask

    task automatic set_exp(input logic [2:0] e0, input logic [2:0] e1,
                           input logic [2:0] e2, input logic [2:0] e3);
        exp_mem[0] = e0;
        exp_mem[1] = e1;
        exp_mem[2] = e2;
        exp_mem[3] = e3;
    endtask

    task automatic read_sweep(input int lo, input int hi);
        logic [2:0] e;
        for (int a = lo; a <= hi; a++) begin
            rd_addr = ADDR_W'(a);
            exp_q.push_back((a < DEPTH) ? exp_mem[a] : 3'b000);
            step();
            e = exp_q.pop_front();
            check($sformatf("rd_data[%0d]", a), 8'(rd_data), 8'(e));
        end
    endtask

    task automatic begin_take();
        start = 1'b1;
        t = 1;
        step();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_mem[i] = 3'b000;
        rst = 1'b0;
        btn1 = 1'b0; btn2 = 1'b0; btn3 = 1'b0;
        start = 1'b0; stop = 1'b0;
        rd_addr = '0;
        step(); step();
        check("rst_rd_data",   8'(rd_data),   8'h0);
        check("rst_recording", 8'(recording), 8'h0);
        check("rst_done",      8'(done),      8'h0);
        check("rst_count",     8'(count),     8'h0);
        check("rst_led",       8'(led),       8'h0);
        rst = 1'b1;
        step(); step();

        // Take 1: btn2 held early in beat 0, then silence until full.
        btn2 = 1'b1;
        begin_take();
        check("t1_recording", 8'(recording), 8'h1);
        goto(3);
        check("t1_led_latency", 8'(led), 8'h0);
        goto(4);
        check("t1_led_btn2", 8'(led), 8'h2);
        goto(5);
        btn2 = 1'b0;
        goto(33);
        check("t1_count3", 8'(count), 8'h3);
        check("t1_not_done", 8'(done), 8'h0);
        goto(34);
        check("t1_count4", 8'(count), 8'h4);
        check("t1_done", 8'(done), 8'h1);
        check("t1_rec_off", 8'(recording), 8'h0);
        check("t1_led_off", 8'(led), 8'h0);
        set_exp(3'b010, 3'b000, 3'b000, 3'b000);
        read_sweep(0, 5);

        // Take 2: single-cycle pulses, and a btn2 press reaching sync on a tick.
        begin_take();
        goto(4);  btn1 = 1'b1;
        goto(5);  btn1 = 1'b0;
        goto(7);
        check("t2_led_btn1", 8'(led), 8'h1);
        goto(9);
        check("t2_led_hold", 8'(led), 8'h1);
        check("t2_count_pre", 8'(count), 8'h0);
        goto(10);
        check("t2_led_clear", 8'(led), 8'h0);
        check("t2_count_first", 8'(count), 8'h1);
        goto(12); btn3 = 1'b1;
        goto(13); btn3 = 1'b0;
        goto(23); btn2 = 1'b1;
        goto(24); btn2 = 1'b0;
        goto(25);
        check("t2_led_pre_tick", 8'(led), 8'h0);
        goto(26);
        check("t2_count3", 8'(count), 8'h3);
        check("t2_led_next", 8'(led), 8'h0);
        goto(34);
        check("t2_done", 8'(done), 8'h1);
        check("t2_count4", 8'(count), 8'h4);
        set_exp(3'b001, 3'b100, 3'b010, 3'b000);
        read_sweep(0, 5);

        // Take 3: start and stop together from DONE, then stop mid-beat 2.
        btn3 = 1'b1;
        stop = 1'b1;
        begin_take();
        stop = 1'b0;
        check("t3_start_wins", 8'(recording), 8'h1);
        goto(20); stop = 1'b1;
        goto(21); stop = 1'b0;
        btn3 = 1'b0;
        check("t3_done", 8'(done), 8'h1);
        check("t3_rec_off", 8'(recording), 8'h0);
        check("t3_count2", 8'(count), 8'h2);
        check("t3_led_off", 8'(led), 8'h0);
        set_exp(3'b100, 3'b100, 3'b010, 3'b000);
        read_sweep(0, 3);

        // Take 4: start ignored during REC, stop coincident with a tick.
        btn1 = 1'b1;
        begin_take();
        goto(10); start = 1'b1;
        goto(11); start = 1'b0;
        check("t4_start_ignored", 8'(count), 8'h1);
        goto(25); stop = 1'b1;
        goto(26); stop = 1'b0;
        btn1 = 1'b0;
        check("t4_done", 8'(done), 8'h1);
        check("t4_count3", 8'(count), 8'h3);
        set_exp(3'b001, 3'b001, 3'b001, 3'b000);
        read_sweep(0, 4);

        // Take 5: asynchronous reset after two writes.
        btn2 = 1'b1;
        begin_take();
        goto(5);  btn2 = 1'b0;
        goto(10); btn3 = 1'b1;
        goto(13); btn3 = 1'b0;
        goto(18); btn1 = 1'b1;
        goto(21);
        check("t5_count2", 8'(count), 8'h2);
        check("t5_led_live", 8'(led), 8'h1);
        rst = 1'b0;
        #1;
        check("t5_rst_rec", 8'(recording), 8'h0);
        check("t5_rst_count", 8'(count), 8'h0);
        check("t5_rst_led", 8'(led), 8'h0);
        check("t5_rst_done", 8'(done), 8'h0);
        step();
        rst = 1'b1;
        btn1 = 1'b0;
        step(); step();
        set_exp(3'b010, 3'b100, 3'b001, 3'b000);
        read_sweep(0, 3);

        // Take 6: new take rewrites entry 0 only.
        btn3 = 1'b1;
        begin_take();
        goto(10);
        check("t6_count1", 8'(count), 8'h1);
        btn3 = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t6_done", 8'(done), 8'h1);
        set_exp(3'b100, 3'b100, 3'b001, 3'b000);
        read_sweep(0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
